// File: rtl/demux_1to2.sv
// -----------------------------------------------------------------------------
// demux_1to2
// Registered 1-to-2 demultiplexer for a wide data word. Each accepted word is
// steered to exactly one output channel by a single control bit, while the
// unselected channel is driven to zero. Per-channel valid strobes and
// saturating transfer counters are provided for debug visibility.
// All outputs are registered, so the latency is exactly one clock.
// -----------------------------------------------------------------------------
module demux_1to2 #(
    parameter int WIDTH = 100,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             control,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             out1_valid,
    output logic             out2_valid,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + CNT_W'(1'b1);
        end
        return result;
    endfunction

    // Routing decision for the current cycle
    logic             route1_s;
    logic             route2_s;

    // Next-state values for the output registers
    logic [WIDTH-1:0] out1_d_s;
    logic [WIDTH-1:0] out2_d_s;
    logic [CNT_W-1:0] cnt1_d_s;
    logic [CNT_W-1:0] cnt2_d_s;

    // Output registers
    logic [WIDTH-1:0] out1_r;
    logic [WIDTH-1:0] out2_r;
    logic             out1_valid_r;
    logic             out2_valid_r;
    logic [CNT_W-1:0] cnt1_r;
    logic [CNT_W-1:0] cnt2_r;

    // Decode which channel (if any) receives the word; control is only
    // examined when in_valid is set, so an unknown control while idle is inert.
    always_comb begin
        route1_s = 1'b0;
        route2_s = 1'b0;
        if (in_valid == 1'b1) begin
            if (control == 1'b0) begin
                route1_s = 1'b1;
                route2_s = 1'b0;
            end else begin
                route1_s = 1'b0;
                route2_s = 1'b1;
            end
        end else begin
            route1_s = 1'b0;
            route2_s = 1'b0;
        end
    end

    // Build next data words: the selected channel gets data_in, the other zero,
    // and nothing stale survives an idle cycle.
    always_comb begin
        out1_d_s = {WIDTH{1'b0}};
        out2_d_s = {WIDTH{1'b0}};
        if (route1_s == 1'b1) begin
            out1_d_s = data_in;
        end else begin
            out1_d_s = {WIDTH{1'b0}};
        end
        if (route2_s == 1'b1) begin
            out2_d_s = data_in;
        end else begin
            out2_d_s = {WIDTH{1'b0}};
        end
    end

    // Next counter values: bump the counter of the channel being routed to.
    always_comb begin
        cnt1_d_s = cnt1_r;
        cnt2_d_s = cnt2_r;
        if (route1_s == 1'b1) begin
            cnt1_d_s = sat_inc(cnt1_r);
        end else begin
            cnt1_d_s = cnt1_r;
        end
        if (route2_s == 1'b1) begin
            cnt2_d_s = sat_inc(cnt2_r);
        end else begin
            cnt2_d_s = cnt2_r;
        end
    end

    // Output and counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_r       <= {WIDTH{1'b0}};
            out2_r       <= {WIDTH{1'b0}};
            out1_valid_r <= 1'b0;
            out2_valid_r <= 1'b0;
            cnt1_r       <= {CNT_W{1'b0}};
            cnt2_r       <= {CNT_W{1'b0}};
        end else begin
            out1_r       <= out1_d_s;
            out2_r       <= out2_d_s;
            out1_valid_r <= route1_s;
            out2_valid_r <= route2_s;
            cnt1_r       <= cnt1_d_s;
            cnt2_r       <= cnt2_d_s;
        end
    end

    assign out1       = out1_r;
    assign out2       = out2_r;
    assign out1_valid = out1_valid_r;
    assign out2_valid = out2_valid_r;
    assign cnt1       = cnt1_r;
    assign cnt2       = cnt2_r;

endmodule

// File: tb/tb_demux_1to2.sv
// -----------------------------------------------------------------------------
// tb_demux_1to2
// Self-checking bench for demux_1to2. A default instance (CNT_W=16) and a
// narrow-counter instance (CNT_W=4) share the same stimulus; a behavioural
// model tracks expected outputs and transfer counts as plain integers.
// -----------------------------------------------------------------------------
module tb_demux_1to2;

    localparam int W = 100;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] data_in;
    logic         control;
    logic         in_valid;

    logic [W-1:0] out1, out2, s_out1, s_out2;
    logic         out1_valid, out2_valid, s_out1_valid, s_out2_valid;
    logic [15:0]  cnt1, cnt2;
    logic [3:0]   s_cnt1, s_cnt2;

    demux_1to2 #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .control(control),
        .in_valid(in_valid), .out1(out1), .out2(out2),
        .out1_valid(out1_valid), .out2_valid(out2_valid),
        .cnt1(cnt1), .cnt2(cnt2)
    );

    demux_1to2 #(.WIDTH(W), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .control(control),
        .in_valid(in_valid), .out1(s_out1), .out2(s_out2),
        .out1_valid(s_out1_valid), .out2_valid(s_out2_valid),
        .cnt1(s_cnt1), .cnt2(s_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Behavioural model state
    logic [W-1:0] m_o1, m_o2;
    logic         m_v1, m_v2;
    int           m_c1, m_c2;

    typedef struct {
        logic         v;
        logic         c;
        logic [W-1:0] d;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
        logic         ev1;
        logic         ev2;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [W-1:0] rnd_word();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_o1 = '0; m_o2 = '0; m_v1 = 1'b0; m_v2 = 1'b0; m_c1 = 0; m_c2 = 0;
    endtask

    // Compare both instances against the model.
    task automatic check_all(input string tag);
        chk({tag, ".out1"}, 128'(out1), 128'(m_o1));
        chk({tag, ".out2"}, 128'(out2), 128'(m_o2));
        chk({tag, ".v1"}, 128'(out1_valid), 128'(m_v1));
        chk({tag, ".v2"}, 128'(out2_valid), 128'(m_v2));
        chk({tag, ".excl"}, 128'(out1_valid & out2_valid), 128'(0));
        chk({tag, ".cnt1"}, 128'(cnt1), 128'(sat(m_c1, 65535)));
        chk({tag, ".cnt2"}, 128'(cnt2), 128'(sat(m_c2, 65535)));
        chk({tag, ".s_out1"}, 128'(s_out1), 128'(m_o1));
        chk({tag, ".s_out2"}, 128'(s_out2), 128'(m_o2));
        chk({tag, ".s_cnt1"}, 128'(s_cnt1), 128'(sat(m_c1, 15)));
        chk({tag, ".s_cnt2"}, 128'(s_cnt2), 128'(sat(m_c2, 15)));
    endtask

    // Apply one cycle of input, advance the model at the edge, check after it.
    task automatic step(input logic v, input logic c, input logic [W-1:0] d, input string tag);
        in_valid = v; control = c; data_in = d;
        @(posedge clk);
        if (v) begin
            if (c == 1'b0) begin
                m_o1 = d; m_v1 = 1'b1; m_o2 = '0; m_v2 = 1'b0; m_c1 = m_c1 + 1;
            end else begin
                m_o2 = d; m_v2 = 1'b1; m_o1 = '0; m_v1 = 1'b0; m_c2 = m_c2 + 1;
            end
        end else begin
            m_o1 = '0; m_o2 = '0; m_v1 = 1'b0; m_v2 = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".out1"}, 128'(out1), 128'(0));
        chk({tag, ".out2"}, 128'(out2), 128'(0));
        chk({tag, ".valids"}, 128'({out1_valid, out2_valid, s_out1_valid, s_out2_valid}), 128'(0));
        chk({tag, ".cnts"}, 128'({cnt1, cnt2, s_cnt1, s_cnt2}), 128'(0));
    endtask

    initial begin
        logic [W-1:0] pat, ones, r;
        logic c;
        pat  = 100'h0000_0000_0000_0000_1234_5678_9ABC;
        ones = {W{1'b1}};

        // Reset held low while traffic is presented
        rst_n = 1'b0; in_valid = 1'b1; control = 1'b0; data_in = ones;
        model_reset();
        #1;
        check_zero("rst_pre_edge");
        @(posedge clk); #1;
        check_zero("rst_post_edge");
        @(negedge clk);
        check_zero("rst_between");
        in_valid = 1'b0; control = 1'b0; data_in = '0;
        rst_n = 1'b1;

        // Directed table: route out1, route out2, alternating, idle with X control
        tbl[0] = '{1'b1, 1'b0, pat,  pat, '0,   1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, ones, '0,  ones, 1'b0, 1'b1};
        for (int i = 2; i < 6; i++) begin
            r = rnd_word();
            c = (i % 2 == 1) ? 1'b1 : 1'b0;
            if (c) tbl[i] = '{1'b1, 1'b1, r, '0, r, 1'b0, 1'b1};
            else   tbl[i] = '{1'b1, 1'b0, r, r, '0, 1'b1, 1'b0};
        end
        tbl[6] = '{1'b0, 1'bx, ones, '0, '0, 1'b0, 1'b0};

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].v, tbl[i].c, tbl[i].d, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.e1", i), 128'(out1), 128'(tbl[i].e1));
            chk($sformatf("tbl%0d.e2", i), 128'(out2), 128'(tbl[i].e2));
            chk($sformatf("tbl%0d.ev", i), 128'({out1_valid, out2_valid}), 128'({tbl[i].ev1, tbl[i].ev2}));
            if (i == 0) chk("first.cnt1", 128'(cnt1), 128'(1));
            if (i == 1) chk("first.cnt2", 128'(cnt2), 128'(1));
        end
        // two from directed rows plus two each from the alternating rows
        chk("alt.cnt1", 128'(cnt1), 128'(3));
        chk("alt.cnt2", 128'(cnt2), 128'(3));

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, rnd_word(),
                 $sformatf("rnd%0d", i));
        end

        // Async reset between edges during traffic
        in_valid = 1'b1; control = 1'b1; data_in = ones;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("async_rst_now");
        @(posedge clk); #1;
        check_zero("async_rst_discard");
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the 4-bit counters
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, rnd_word(), $sformatf("sat%0d", i));
        end
        chk("sat.s_cnt1", 128'(s_cnt1), 128'(15));
        chk("sat.s_cnt2", 128'(s_cnt2), 128'(0));
        chk("sat.cnt1", 128'(cnt1), 128'(20));
        step(1'b1, 1'b1, ones, "sat_c2");
        chk("sat.s_cnt1_hold", 128'(s_cnt1), 128'(15));
        chk("sat.s_cnt2_one", 128'(s_cnt2), 128'(1));
        step(1'b0, 1'b0, '0, "sat_idle");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
